// File: rtl/soft_trigger_gen_pkg.sv
// Shared definitions for the software trigger generator: channel FSM
// encodings and the minimum legal trigger period.
package soft_trigger_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_DELAY = 2'b01,
    ST_RUN   = 2'b10,
    ST_DONE  = 2'b11
  } trig_state_e;

  // Shortest period that still leaves room for one high and one low cycle.
  localparam int unsigned TRIG_MIN_CYCLE = 2;

endpackage

// File: rtl/soft_trigger_gen_chan.sv
// One software trigger channel: enable delay line with rising-edge arm,
// shadow configuration captured at arm, IDLE/DELAY/RUN/DONE sequencer and
// the period, delay and fired counters. All outputs are registered.
module soft_trigger_chan
  import soft_trigger_gen_pkg::*;
#(
  parameter int CNT_W       = 32,
  parameter int SYNC_STAGES = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [CNT_W-1:0] cycle,
  input  logic [CNT_W-1:0] width,
  input  logic [CNT_W-1:0] delay,
  input  logic [CNT_W-1:0] num,
  output logic             soft_trigger,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] fired
);

  localparam logic [CNT_W-1:0] MIN_CYC = CNT_W'(TRIG_MIN_CYCLE);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  // Period is never shorter than the minimum legal cycle.
  function automatic logic [CNT_W-1:0] clamp_cycle(input logic [CNT_W-1:0] c);
    return (c < MIN_CYC) ? MIN_CYC : c;
  endfunction

  // Pulse width is limited so every period keeps at least one low cycle.
  function automatic logic [CNT_W-1:0] clamp_width(input logic [CNT_W-1:0] w,
                                                   input logic [CNT_W-1:0] c);
    return (w > (c - ONE)) ? (c - ONE) : w;
  endfunction

  // Fired counter sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : (v + ONE);
  endfunction

  logic [SYNC_STAGES:0] en_d;
  logic                 en_s;
  logic                 arm;

  logic [CNT_W-1:0] cyc_in, wid_in;
  logic [CNT_W-1:0] cyc_sh, wid_sh, dly_sh, num_sh;

  trig_state_e      state, state_n;
  logic [CNT_W-1:0] pcnt, pcnt_n, pcnt_inc;
  logic [CNT_W-1:0] dly_cnt, dly_n;
  logic [CNT_W-1:0] fired_q, fired_n, fired_inc;
  logic             trig_q, trig_n;
  logic             busy_q, busy_n;
  logic             done_q, done_n;
  logic             latch;

  assign en_s = en_d[SYNC_STAGES-1];
  assign arm  = en_s & ~en_d[SYNC_STAGES];

  assign cyc_in    = clamp_cycle(cycle);
  assign wid_in    = clamp_width(width, cyc_in);
  assign pcnt_inc  = pcnt + ONE;
  assign fired_inc = sat_inc(fired_q);

  // Enable delay line; the last two taps form the arm edge detector.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_d <= '0;
    end else begin
      en_d <= {en_d[SYNC_STAGES-1:0], en};
    end
  end

  // Shadow configuration, captured only when the channel arms.
  always_ff @(posedge clk) begin
    if (latch) begin
      cyc_sh <= cyc_in;
      wid_sh <= wid_in;
      dly_sh <= delay;
      num_sh <= num;
    end
  end

  // Next-state, counter and registered-output decode.
  always_comb begin
    state_n = state;
    pcnt_n  = pcnt;
    dly_n   = dly_cnt;
    fired_n = fired_q;
    trig_n  = 1'b0;
    busy_n  = 1'b0;
    done_n  = 1'b0;
    latch   = 1'b0;
    if (!en_s) begin
      // Enable removal wins over everything, including a burst ending now.
      state_n = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (arm) begin
            latch   = 1'b1;
            fired_n = '0;
            pcnt_n  = '0;
            dly_n   = '0;
            busy_n  = 1'b1;
            if (delay == '0) begin
              state_n = ST_RUN;
              trig_n  = (wid_in != '0);
            end else begin
              state_n = ST_DELAY;
            end
          end
        end
        ST_DELAY: begin
          busy_n = 1'b1;
          if (dly_cnt == (dly_sh - ONE)) begin
            state_n = ST_RUN;
            pcnt_n  = '0;
            trig_n  = (wid_sh != '0);
          end else begin
            dly_n = dly_cnt + ONE;
          end
        end
        ST_RUN: begin
          if (pcnt == (cyc_sh - ONE)) begin
            pcnt_n  = '0;
            fired_n = fired_inc;
            if ((num_sh != '0) && (fired_inc == num_sh)) begin
              state_n = ST_DONE;
              done_n  = 1'b1;
            end else begin
              busy_n = 1'b1;
              trig_n = (wid_sh != '0);
            end
          end else begin
            pcnt_n = pcnt_inc;
            busy_n = 1'b1;
            trig_n = (pcnt_inc < wid_sh);
          end
        end
        ST_DONE: begin
          state_n = ST_DONE;
        end
        default: begin
          state_n = ST_IDLE;
        end
      endcase
    end
  end

  // Sequencer state, counters and output flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      pcnt    <= '0;
      dly_cnt <= '0;
      fired_q <= '0;
      trig_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state   <= state_n;
      pcnt    <= pcnt_n;
      dly_cnt <= dly_n;
      fired_q <= fired_n;
      trig_q  <= trig_n;
      busy_q  <= busy_n;
      done_q  <= done_n;
    end
  end

  assign soft_trigger = trig_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign fired        = fired_q;

endmodule

// File: rtl/soft_trigger_gen.sv
// Multi-channel software trigger generator: CH_NUM independent channels,
// each with its own slice of the packed configuration and status buses.
module soft_trigger_gen
  import soft_trigger_gen_pkg::*;
#(
  parameter int CH_NUM      = 4,
  parameter int CNT_W       = 32,
  parameter int SYNC_STAGES = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [CH_NUM-1:0]       reg_trig_en,
  input  logic [CH_NUM*CNT_W-1:0] reg_trig_cycle,
  input  logic [CH_NUM*CNT_W-1:0] reg_trig_width,
  input  logic [CH_NUM*CNT_W-1:0] reg_trig_delay,
  input  logic [CH_NUM*CNT_W-1:0] reg_trig_num,
  output logic [CH_NUM-1:0]       soft_trigger,
  output logic [CH_NUM-1:0]       trig_busy,
  output logic [CH_NUM-1:0]       trig_done,
  output logic [CH_NUM*CNT_W-1:0] trig_fired
);

  for (genvar i = 0; i < CH_NUM; i++) begin : g_ch
    soft_trigger_chan #(
      .CNT_W       (CNT_W),
      .SYNC_STAGES (SYNC_STAGES)
    ) u_chan (
      .clk          (clk),
      .rst          (rst),
      .en           (reg_trig_en[i]),
      .cycle        (reg_trig_cycle[i*CNT_W +: CNT_W]),
      .width        (reg_trig_width[i*CNT_W +: CNT_W]),
      .delay        (reg_trig_delay[i*CNT_W +: CNT_W]),
      .num          (reg_trig_num[i*CNT_W +: CNT_W]),
      .soft_trigger (soft_trigger[i]),
      .busy         (trig_busy[i]),
      .done         (trig_done[i]),
      .fired        (trig_fired[i*CNT_W +: CNT_W])
    );
  end

endmodule

// File: tb/tb_soft_trigger_gen.sv
// Bench for soft_trigger_gen: closed-form per-channel reference model checked
// every cycle, plus directed scenarios with hand-computed edge expectations.
module tb_soft_trigger_gen;

  localparam int CH = 4;
  localparam int W  = 32;
  localparam int S  = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic [CH-1:0]     en;
  logic [CH*W-1:0]   cyc_b, wid_b, dly_b, num_b;
  logic [CH-1:0]     soft_trigger, trig_busy, trig_done;
  logic [CH*W-1:0]   trig_fired;

  soft_trigger_gen #(.CH_NUM(CH), .CNT_W(W), .SYNC_STAGES(S)) dut (
    .clk            (clk),
    .rst            (rst),
    .reg_trig_en    (en),
    .reg_trig_cycle (cyc_b),
    .reg_trig_width (wid_b),
    .reg_trig_delay (dly_b),
    .reg_trig_num   (num_b),
    .soft_trigger   (soft_trigger),
    .trig_busy      (trig_busy),
    .trig_done      (trig_done),
    .trig_fired     (trig_fired)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  task automatic set_cfg(input int c, input longint cy, input longint wd,
                         input longint dl, input longint nm);
    cyc_b[c*W +: W] = W'(cy);
    wid_b[c*W +: W] = W'(wd);
    dly_b[c*W +: W] = W'(dl);
    num_b[c*W +: W] = W'(nm);
  endtask

  function automatic logic [63:0] fired_of(input int c);
    return {32'd0, trig_fired[c*W +: W]};
  endfunction

  // ---------------- reference model ----------------
  // Raw enable history: the channel sees its enable S edges late and arms
  // on the first edge where that delayed level is high after being low.
  // Once armed, outputs follow directly from elapsed edges since arm.
  bit [CH-1:0] ring [16];
  int          n = 32;
  bit          armed   [CH];
  longint      arm_n   [CH];
  longint      m_cyc   [CH], m_wid [CH], m_dly [CH], m_num [CH], m_fired [CH];
  bit          e_trig  [CH], e_busy [CH], e_done [CH];
  longint      t, u, k, ph;
  bit          s_lvl, p_lvl;

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) ring[i] = '0;
      n = 32;
      for (int c = 0; c < CH; c++) begin
        armed[c] = 0; m_fired[c] = 0;
        e_trig[c] = 0; e_busy[c] = 0; e_done[c] = 0;
      end
    end else begin
      ring[n % 16] = en;
      for (int c = 0; c < CH; c++) begin
        s_lvl = ring[(n - S) % 16][c];
        p_lvl = ring[(n - S - 1) % 16][c];
        if (!s_lvl) begin
          armed[c] = 0;
          e_trig[c] = 0; e_busy[c] = 0; e_done[c] = 0;
        end else begin
          if (!p_lvl) begin
            armed[c]  = 1;
            arm_n[c]  = n;
            m_cyc[c]  = (cyc_b[c*W +: W] < 2) ? 2 : longint'(cyc_b[c*W +: W]);
            m_wid[c]  = (wid_b[c*W +: W] > m_cyc[c] - 1) ? m_cyc[c] - 1
                                                          : longint'(wid_b[c*W +: W]);
            m_dly[c]  = longint'(dly_b[c*W +: W]);
            m_num[c]  = longint'(num_b[c*W +: W]);
          end
          t = n - arm_n[c];
          if (t < m_dly[c]) begin
            e_trig[c] = 0; e_busy[c] = 1; e_done[c] = 0; m_fired[c] = 0;
          end else begin
            u  = t - m_dly[c];
            k  = u / m_cyc[c];
            ph = u % m_cyc[c];
            if (m_num[c] != 0 && k >= m_num[c]) begin
              e_trig[c] = 0; e_busy[c] = 0;
              e_done[c] = (u == m_num[c] * m_cyc[c]);
              m_fired[c] = m_num[c];
            end else begin
              e_trig[c] = (ph < m_wid[c]); e_busy[c] = 1; e_done[c] = 0;
              m_fired[c] = (k > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : k;
            end
          end
        end
      end
      n++;
    end
    #1;
    for (int c = 0; c < CH; c++) begin
      chk($sformatf("m_trig_ch%0d", c),  soft_trigger[c], e_trig[c]);
      chk($sformatf("m_busy_ch%0d", c),  trig_busy[c],    e_busy[c]);
      chk($sformatf("m_done_ch%0d", c),  trig_done[c],    e_done[c]);
      chk($sformatf("m_fired_ch%0d", c), fired_of(c),     m_fired[c]);
    end
  end

  // ---------------- directed + random stimulus ----------------
  task automatic idle_wait(input int cycles);
    repeat (cycles) @(posedge clk);
    #2;
  endtask

  task automatic rise(input int c);
    @(negedge clk);
    en[c] = 1'b1;
  endtask

  task automatic drop_and_wait(input int c);
    @(negedge clk);
    en[c] = 1'b0;
    idle_wait(S + 4);
  endtask

  initial begin
    rst = 1'b1;
    en  = '0;
    for (int c = 0; c < CH; c++) set_cfg(c, 4, 1, 0, 0);
    repeat (3) @(posedge clk);
    #2;
    chk("rst_trig",  soft_trigger, 0);
    chk("rst_busy",  trig_busy,    0);
    chk("rst_done",  trig_done,    0);
    chk("rst_fired", trig_fired,   0);
    @(negedge clk);
    rst = 1'b0;
    idle_wait(6);

    // Finite burst: 4 pulses, 3 high / 7 low, first at edge 3.
    set_cfg(0, 10, 3, 0, 4);
    rise(0);
    for (int e = 0; e <= 45; e++) begin
      @(posedge clk); #2;
      case (e)
        2:  chk("b_trig_e2", soft_trigger[0], 0);
        3:  begin chk("b_trig_e3", soft_trigger[0], 1); chk("b_busy_e3", trig_busy[0], 1); end
        5:  chk("b_trig_e5", soft_trigger[0], 1);
        6:  chk("b_trig_e6", soft_trigger[0], 0);
        13: chk("b_trig_e13", soft_trigger[0], 1);
        33: chk("b_fired_e33", fired_of(0), 3);
        42: begin chk("b_busy_e42", trig_busy[0], 1); chk("b_done_e42", trig_done[0], 0); end
        43: begin
          chk("b_done_e43", trig_done[0], 1);
          chk("b_busy_e43", trig_busy[0], 0);
          chk("b_fired_e43", fired_of(0), 4);
          chk("model_done_e43", e_done[0], 1);
        end
        44: chk("b_done_e44", trig_done[0], 0);
        default: ;
      endcase
    end
    drop_and_wait(0);

    // Continuous with delay 7; enable dropped before edge 18 truncates at 21.
    set_cfg(1, 5, 2, 7, 0);
    rise(1);
    for (int e = 0; e <= 25; e++) begin
      @(posedge clk); #2;
      case (e)
        9:  begin chk("c_trig_e9", soft_trigger[1], 0); chk("c_busy_e9", trig_busy[1], 1); end
        10: begin chk("c_trig_e10", soft_trigger[1], 1); chk("model_trig_e10", e_trig[1], 1); end
        12: chk("c_trig_e12", soft_trigger[1], 0);
        15: chk("c_trig_e15", soft_trigger[1], 1);
        17: en[1] = 1'b0;
        20: begin chk("c_trig_e20", soft_trigger[1], 1); chk("c_fired_e20", fired_of(1), 2); end
        21: begin
          chk("c_trig_e21", soft_trigger[1], 0);
          chk("c_busy_e21", trig_busy[1], 0);
          chk("c_done_e21", trig_done[1], 0);
          chk("c_fired_e21", fired_of(1), 2);
        end
        default: ;
      endcase
    end
    idle_wait(4);

    // Clamps: cycle 1 / width 9 behaves as period 2, width 1.
    set_cfg(2, 1, 9, 0, 0);
    rise(2);
    for (int e = 0; e <= 8; e++) begin
      @(posedge clk); #2;
      if (e >= 3) chk($sformatf("cl_trig_e%0d", e), soft_trigger[2], (e % 2 == 1) ? 1 : 0);
    end
    drop_and_wait(2);

    // Width 0: no pulses, periods still counted, done at edge 15.
    set_cfg(2, 4, 0, 0, 3);
    rise(2);
    for (int e = 0; e <= 17; e++) begin
      @(posedge clk); #2;
      chk($sformatf("w0_trig_e%0d", e), soft_trigger[2], 0);
      if (e == 14) begin chk("w0_busy_e14", trig_busy[2], 1); chk("w0_fired_e14", fired_of(2), 2); end
      if (e == 15) begin chk("w0_done_e15", trig_done[2], 1); chk("w0_fired_e15", fired_of(2), 3); end
    end
    drop_and_wait(2);

    // Config change mid-burst is ignored until the next arm.
    set_cfg(3, 10, 2, 0, 3);
    rise(3);
    for (int e = 0; e <= 35; e++) begin
      @(posedge clk); #2;
      if (e == 10) set_cfg(3, 20, 2, 0, 3);
      if (e == 13) chk("cc_trig_e13", soft_trigger[3], 1);
      if (e == 23) chk("cc_trig_e23", soft_trigger[3], 1);
      if (e == 33) chk("cc_done_e33", trig_done[3], 1);
    end
    drop_and_wait(3);
    rise(3);
    for (int e = 0; e <= 64; e++) begin
      @(posedge clk); #2;
      if (e == 13) chk("cc2_trig_e13", soft_trigger[3], 0);
      if (e == 23) chk("cc2_trig_e23", soft_trigger[3], 1);
      if (e == 33) chk("cc2_done_e33", trig_done[3], 0);
      if (e == 63) chk("cc2_done_e63", trig_done[3], 1);
    end
    drop_and_wait(3);

    // Two-cycle enable pulse arms, then returns to idle.
    set_cfg(0, 4, 1, 0, 0);
    rise(0);
    for (int e = 0; e <= 6; e++) begin
      @(posedge clk); #2;
      if (e == 1) en[0] = 1'b0;
      if (e == 3) begin chk("ep_busy_e3", trig_busy[0], 1); chk("ep_trig_e3", soft_trigger[0], 1); end
      if (e == 4) begin chk("ep_busy_e4", trig_busy[0], 1); chk("ep_trig_e4", soft_trigger[0], 0); end
      if (e == 5) chk("ep_busy_e5", trig_busy[0], 0);
    end
    idle_wait(4);

    // Asynchronous reset while the output is high.
    set_cfg(0, 6, 3, 0, 0);
    rise(0);
    for (int e = 0; e <= 4; e++) begin
      @(posedge clk); #2;
    end
    chk("ar_trig_before", soft_trigger[0], 1);
    rst = 1'b1;
    #1;
    chk("ar_trig", soft_trigger, 0);
    chk("ar_busy", trig_busy, 0);
    chk("ar_done", trig_done, 0);
    chk("ar_fired", trig_fired, 0);
    en = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    idle_wait(6);
    chk("ar_busy_after", trig_busy[0], 0);
    rise(0);
    for (int e = 0; e <= 3; e++) begin
      @(posedge clk); #2;
    end
    chk("ar_rearm_trig", soft_trigger[0], 1);
    drop_and_wait(0);

    // Randomised traffic on all channels against the model.
    for (int it = 0; it < 2500; it++) begin
      @(negedge clk);
      if (it == 1200) rst = 1'b1;
      if (it == 1202) rst = 1'b0;
      for (int c = 0; c < CH; c++) begin
        if ($urandom_range(0, 39) == 0) en[c] = ~en[c];
        if ($urandom_range(0, 29) == 0)
          set_cfg(c, $urandom_range(0, 9), $urandom_range(0, 10),
                  $urandom_range(0, 6), $urandom_range(0, 4));
      end
    end
    en = '0;
    idle_wait(8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
